// File: rtl/alu_sequencer.sv
// Fetch/execute sequencer that issues instructions to the ALU and acts on its result strobes.
// Optional feature: define SEQ_STEP_EN to gate instruction acceptance with the step input.
module alu_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SEQ_STEP_EN
  input  logic            step,
`endif
  input  logic [7:0]      instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      alu_opcode,
  output logic [3:0]      alu_addrs,
  output logic [7:0]      alu_din0,
  output logic [7:0]      alu_din1,
  input  logic [7:0]      alu_dout,
  input  logic            alu_carry,
  input  logic            alu_borrow,
  input  logic            alu_carry_en,
  input  logic            alu_bcf,
  input  logic            alu_mem_write,
  input  logic            alu_mem_read,
  input  logic            alu_toggle,
  output logic [7:0]      mem_addr,
  output logic [7:0]      mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [7:0]      mem_rdata,
  input  logic            mem_ack,
  output logic            carry_flag,
  output logic            toggle_out
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, MEM} state_t;

  state_t          state, state_next;
  logic [7:0]      ir;
  logic [7:0]      rf [4];
  logic            accept;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] branch_target;

  assign alu_opcode    = ir[7:6];
  assign alu_addrs     = ir[5:2];
  assign alu_din0      = rf[0];
  assign alu_din1      = rf[ir[1:0]];
  assign accept        = instr_valid & instr_ready;
  assign pc_inc        = pc + PC_W'(1);
  assign branch_target = PC_W'(alu_dout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
`ifdef SEQ_STEP_EN
        instr_ready = step;
`else
        instr_ready = 1'b1;
`endif
        if (instr_valid && instr_ready) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (alu_mem_write || alu_mem_read) begin
          state_next = MEM;
        end else begin
          state_next = FETCH;
        end
      end
      MEM: begin
        if (mem_ack) begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Architectural state: one strobe acts per EXEC; the carry flag updates independently of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir         <= '0;
      pc         <= '0;
      carry_flag <= 1'b0;
      toggle_out <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        rf[i] <= '0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (accept) begin
            ir <= instr;
          end
        end
        EXEC: begin
          if (alu_carry_en) begin
            if (ir[7:6] == 2'd0) begin
              carry_flag <= alu_carry;
            end else if (ir[7:6] == 2'd1) begin
              carry_flag <= alu_borrow;
            end
          end
          if (alu_mem_write) begin
            mem_addr  <= rf[0];
            mem_wdata <= rf[ir[1:0]];
            mem_we    <= 1'b1;
          end else if (alu_mem_read) begin
            mem_addr <= rf[ir[1:0]];
            mem_re   <= 1'b1;
          end else if (alu_bcf) begin
            pc <= carry_flag ? pc_inc : branch_target;
          end else if (alu_toggle) begin
            toggle_out <= ~toggle_out;
            pc         <= pc_inc;
          end else begin
            if (ir[7:6] == 2'd3) begin
              rf[ir[3:2]] <= alu_dout;
            end else begin
              rf[0] <= alu_dout;
            end
            pc <= pc_inc;
          end
        end
        MEM: begin
          if (mem_ack) begin
            if (mem_re) begin
              rf[0] <= mem_rdata;
            end
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            pc     <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: the bench plays both the ALU and the data memory.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] pc;
  logic [1:0] alu_opcode;
  logic [3:0] alu_addrs;
  logic [7:0] alu_din0;
  logic [7:0] alu_din1;
  logic [7:0] alu_dout;
  logic       alu_carry;
  logic       alu_borrow;
  logic       alu_carry_en;
  logic       alu_bcf;
  logic       alu_mem_write;
  logic       alu_mem_read;
  logic       alu_toggle;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       carry_flag;
  logic       toggle_out;
`ifdef SEQ_STEP_EN
  logic       step;
`endif

  int n_asserts;
  int n_fail;

  logic [1:0] exec_opcode;
  logic [3:0] exec_addrs;
  logic [7:0] exec_din0;
  logic [7:0] exec_din1;

  // Strobe bundle bits: {mem_write, mem_read, bcf, toggle, carry_en, carry, borrow}
  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_MW   = 7'b1000000;
  localparam logic [6:0] S_MR   = 7'b0100000;
  localparam logic [6:0] S_BCF  = 7'b0010000;
  localparam logic [6:0] S_TOG  = 7'b0001000;
  localparam logic [6:0] S_CEN  = 7'b0000100;
  localparam logic [6:0] S_CY   = 7'b0000010;

  alu_sequencer #(.PC_W(8)) dut (
    .clk(clk),
    .rst(rst),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc(pc),
    .alu_opcode(alu_opcode),
    .alu_addrs(alu_addrs),
    .alu_din0(alu_din0),
    .alu_din1(alu_din1),
    .alu_dout(alu_dout),
    .alu_carry(alu_carry),
    .alu_borrow(alu_borrow),
    .alu_carry_en(alu_carry_en),
    .alu_bcf(alu_bcf),
    .alu_mem_write(alu_mem_write),
    .alu_mem_read(alu_mem_read),
    .alu_toggle(alu_toggle),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .carry_flag(carry_flag),
    .toggle_out(toggle_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from a FETCH negedge; returns at the negedge after the EXEC edge.
  task automatic apply_stimulus(input logic [7:0] ins, input logic [7:0] dout, input logic [6:0] strb);
    int waited;
    waited = 0;
    while (instr_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_output("ready_wait", 8'(instr_ready), 8'h01);
    instr         = ins;
    instr_valid   = 1'b1;
    alu_dout      = dout;
    alu_mem_write = strb[6];
    alu_mem_read  = strb[5];
    alu_bcf       = strb[4];
    alu_toggle    = strb[3];
    alu_carry_en  = strb[2];
    alu_carry     = strb[1];
    alu_borrow    = strb[0];
    @(negedge clk);
    instr_valid = 1'b0;
    exec_opcode = alu_opcode;
    exec_addrs  = alu_addrs;
    exec_din0   = alu_din0;
    exec_din1   = alu_din1;
    @(negedge clk);
    alu_dout      = 8'h00;
    alu_mem_write = 1'b0;
    alu_mem_read  = 1'b0;
    alu_bcf       = 1'b0;
    alu_toggle    = 1'b0;
    alu_carry_en  = 1'b0;
    alu_carry     = 1'b0;
    alu_borrow    = 1'b0;
  endtask

  initial begin
    n_asserts     = 0;
    n_fail        = 0;
    rst           = 1'b1;
    instr         = 8'h00;
    instr_valid   = 1'b0;
    alu_dout      = 8'h00;
    alu_carry     = 1'b0;
    alu_borrow    = 1'b0;
    alu_carry_en  = 1'b0;
    alu_bcf       = 1'b0;
    alu_mem_write = 1'b0;
    alu_mem_read  = 1'b0;
    alu_toggle    = 1'b0;
    mem_rdata     = 8'h00;
    mem_ack       = 1'b0;
`ifdef SEQ_STEP_EN
    step          = 1'b1;
`endif

    @(negedge clk);
    check_output("rst_pc", pc, 8'h00);
    check_output("rst_ready", 8'(instr_ready), 8'h00);
    check_output("rst_we_re", 8'({mem_we, mem_re}), 8'h00);
    check_output("rst_mem_addr", mem_addr, 8'h00);
    check_output("rst_mem_wdata", mem_wdata, 8'h00);
    check_output("rst_flags", 8'({carry_flag, toggle_out}), 8'h00);
    check_output("rst_alu_drive", 8'({alu_opcode, alu_addrs}), 8'h00);
    check_output("rst_din0", alu_din0, 8'h00);
    check_output("rst_din1", alu_din1, 8'h00);
    rst = 1'b0;
    check_output("idle_ready", 8'(instr_ready), 8'h00);
    @(negedge clk);
    check_output("fetch_ready", 8'(instr_ready), 8'h01);

    // Load r1=0x20 and r0=0xF0 through mov write-back
    apply_stimulus(8'hC4, 8'h20, S_NONE);
    check_output("mov_r1_pc", pc, 8'h01);
    apply_stimulus(8'hC0, 8'hF0, S_NONE);
    check_output("mov_r0_din0", alu_din0, 8'hF0);
    check_output("mov_r0_pc", pc, 8'h02);

    // add r0,r1 with carry out
    apply_stimulus(8'h01, 8'h10, S_CEN | S_CY);
    check_output("add_exec_opcode", 8'(exec_opcode), 8'h00);
    check_output("add_exec_din0", exec_din0, 8'hF0);
    check_output("add_exec_din1", exec_din1, 8'h20);
    check_output("add_r0", alu_din0, 8'h10);
    check_output("add_carry", 8'(carry_flag), 8'h01);
    check_output("add_pc", pc, 8'h03);

    // Branch not taken while carry set
    apply_stimulus(8'hC0, 8'h40, S_BCF);
    check_output("bcf_c1_pc", pc, 8'h04);
    check_output("bcf_c1_r0", alu_din0, 8'h10);

    // sub clears the flag from borrow, not carry
    apply_stimulus(8'h41, 8'h10, S_CEN | S_CY);
    check_output("sub_exec_opcode", 8'(exec_opcode), 8'h01);
    check_output("sub_carry", 8'(carry_flag), 8'h00);
    check_output("sub_pc", pc, 8'h05);

    apply_stimulus(8'hC0, 8'h40, S_BCF);
    check_output("bcf_c0_pc", pc, 8'h40);
    apply_stimulus(8'hC0, 8'h40, S_BCF);
    check_output("bcf_self_pc", pc, 8'h40);

    apply_stimulus(8'hC8, 8'h33, S_NONE);
    check_output("mov_r2_addrs", 8'(exec_addrs), 8'h02);
    check_output("mov_r2_pc", pc, 8'h41);

    // Memory read acked in the third MEM cycle
    apply_stimulus(8'h02, 8'h00, S_MR);
    check_output("rd_c1_re", 8'(mem_re), 8'h01);
    check_output("rd_c1_we", 8'(mem_we), 8'h00);
    check_output("rd_c1_addr", mem_addr, 8'h33);
    @(negedge clk);
    check_output("rd_c2_re", 8'(mem_re), 8'h01);
    @(negedge clk);
    check_output("rd_c3_re", 8'(mem_re), 8'h01);
    check_output("rd_c3_addr", mem_addr, 8'h33);
    mem_ack   = 1'b1;
    mem_rdata = 8'hA5;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    check_output("rd_done_re", 8'(mem_re), 8'h00);
    check_output("rd_r0", alu_din0, 8'hA5);
    check_output("rd_pc", pc, 8'h42);

    // Write and bcf together: write wins, no branch
    apply_stimulus(8'h02, 8'h80, S_MW | S_BCF);
    check_output("wr_we", 8'(mem_we), 8'h01);
    check_output("wr_re", 8'(mem_re), 8'h00);
    check_output("wr_addr", mem_addr, 8'hA5);
    check_output("wr_wdata", mem_wdata, 8'h33);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_output("wr_done_we", 8'(mem_we), 8'h00);
    check_output("wr_pc", pc, 8'h43);
    check_output("wr_r0", alu_din0, 8'hA5);

    // pc wrap on toggle
    apply_stimulus(8'hC0, 8'hFF, S_BCF);
    check_output("bcf_ff_pc", pc, 8'hFF);
    apply_stimulus(8'hC0, 8'h77, S_TOG);
    check_output("tog_out", 8'(toggle_out), 8'h01);
    check_output("tog_pc_wrap", pc, 8'h00);
    check_output("tog_r0", alu_din0, 8'hA5);

    apply_stimulus(8'h00, 8'h5A, S_CEN | S_CY);
    check_output("add2_r0", alu_din0, 8'h5A);
    check_output("add2_carry", 8'(carry_flag), 8'h01);
    check_output("add2_pc", pc, 8'h01);

    // Reset in the middle of a pending write
    apply_stimulus(8'h02, 8'h00, S_MW);
    check_output("mid_we", 8'(mem_we), 8'h01);
    check_output("mid_addr", mem_addr, 8'h5A);
    #2;
    rst = 1'b1;
    #1;
    check_output("arst_we", 8'(mem_we), 8'h00);
    check_output("arst_pc", pc, 8'h00);
    check_output("arst_r0", alu_din0, 8'h00);
    check_output("arst_din1", alu_din1, 8'h00);
    check_output("arst_flags", 8'({carry_flag, toggle_out}), 8'h00);
    check_output("arst_addr", mem_addr, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    check_output("arst_idle_ready", 8'(instr_ready), 8'h00);
    @(negedge clk);
    check_output("arst_fetch_ready", 8'(instr_ready), 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
